// File: rtl/chacha20_ks_xor_stage_pkg.sv
// rtl/chacha20_ks_xor_stage_pkg.sv - shared constants, state type and keep helpers for the keystream XOR stage
package chacha_pim_pkg;

  localparam int DATA_W = 128;
  localparam int KS_W   = 512;
  localparam int LANES  = KS_W / DATA_W;
  localparam int CNT_W  = 64;
  localparam int KEEP_W = DATA_W / 8;
  localparam int LANE_W = $clog2(LANES);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_KS,
    STREAM,
    DRAIN
  } state_t;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) begin
      c = c + {4'd0, v[i]};
    end
    return c;
  endfunction

  // A prefix mask has no set bit above a clear bit, so adding one clears every set bit.
  function automatic logic keep_is_prefix(input logic [KEEP_W-1:0] k);
    return (k & (k + KEEP_W'(1))) == '0;
  endfunction

  function automatic logic [DATA_W-1:0] keep_to_mask(input logic [KEEP_W-1:0] k);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int j = 0; j < KEEP_W; j++) begin
      m[8*j +: 8] = {8{k[j]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/chacha20_ks_xor_stage_if.sv
// rtl/chacha20_ks_xor_stage_if.sv - payload in, result out and Poly1305 payload streams of the XOR stage
interface chacha20_ks_xor_stage_if;
  import chacha_pim_pkg::*;

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic [KEEP_W-1:0] in_keep;
  logic              in_last;
  logic              in_ready;

  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [KEEP_W-1:0] out_keep;
  logic              out_last;
  logic              out_ready;

  logic              pld_valid;
  logic [DATA_W-1:0] pld_data;
  logic [KEEP_W-1:0] pld_keep;
  logic              pld_ready;

  modport slave (
    input  in_valid, in_data, in_keep, in_last, out_ready, pld_ready,
    output in_ready, out_valid, out_data, out_keep, out_last,
           pld_valid, pld_data, pld_keep
  );

  modport master (
    output in_valid, in_data, in_keep, in_last, out_ready, pld_ready,
    input  in_ready, out_valid, out_data, out_keep, out_last,
           pld_valid, pld_data, pld_keep
  );

endinterface

// File: rtl/chacha20_ks_xor_stage_lane_buf.sv
// rtl/chacha20_ks_xor_stage_lane_buf.sv - holds one keystream block and walks its 128-bit lanes
module chacha_ks_lane_buf
  import chacha_pim_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              advance,
  input  logic [KS_W-1:0]   ks_data,
  output logic [DATA_W-1:0] lane_data,
  output logic              last_lane
);

  logic [KS_W-1:0]   ks_buf;
  logic [LANE_W-1:0] lane;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ks_buf <= '0;
      lane   <= '0;
    end else if (load) begin
      ks_buf <= ks_data;
      lane   <= '0;
    end else if (advance) begin
      lane   <= lane + LANE_W'(1);
    end
  end

  assign lane_data = ks_buf[int'(lane) * DATA_W +: DATA_W];
  assign last_lane = (lane == LANE_W'(LANES - 1));

endmodule

// File: rtl/chacha20_ks_xor_stage.sv
// rtl/chacha20_ks_xor_stage.sv - XORs payload beats with keystream lanes and feeds ciphertext to Poly1305
module chacha20_ks_xor_stage
  import chacha_pim_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   dir_enc,
  output logic                   ks_req,
  input  logic                   ks_valid,
  input  logic [KS_W-1:0]        ks_data,
  chacha20_ks_xor_stage_if.slave bus,
  output logic [CNT_W-1:0]       pld_byte_cnt,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  state_t state, state_nx;

  logic              enc_q;
  logic              out_valid_q, out_last_q, pld_valid_q, err_q;
  logic [DATA_W-1:0] out_data_q, pld_data_q;
  logic [KEEP_W-1:0] out_keep_q, pld_keep_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              in_ready_c, accept, keep_err;
  logic              ks_load, last_lane;
  logic [DATA_W-1:0] lane_data, byte_mask, xor_data, pld_next;

  chacha_ks_lane_buf u_lane_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (ks_load),
    .advance   (accept),
    .ks_data   (ks_data),
    .lane_data (lane_data),
    .last_lane (last_lane)
  );

  // Both result registers must be free (or freeing this cycle) before a beat is taken.
  assign in_ready_c = (state == STREAM)
                    & (!out_valid_q | bus.out_ready)
                    & (!pld_valid_q | bus.pld_ready);
  assign accept     = bus.in_valid & in_ready_c;
  assign ks_load    = (state == WAIT_KS) & ks_valid;

  assign byte_mask = keep_to_mask(bus.in_keep);
  assign xor_data  = (bus.in_data ^ lane_data) & byte_mask;
  assign pld_next  = enc_q ? xor_data : (bus.in_data & byte_mask);
  assign keep_err  = !keep_is_prefix(bus.in_keep)
                   | (!bus.in_last & (bus.in_keep != '1))
                   | (bus.in_keep == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = REQ;
      REQ:     state_nx = WAIT_KS;
      WAIT_KS: if (ks_valid) state_nx = STREAM;
      STREAM: begin
        if (accept) begin
          if (bus.in_last)    state_nx = DRAIN;
          else if (last_lane) state_nx = REQ;
        end
      end
      DRAIN:   if (!out_valid_q && !pld_valid_q) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      pld_valid_q <= 1'b0;
      pld_data_q  <= '0;
      pld_keep_q  <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        enc_q <= dir_enc;
        cnt_q <= '0;
        err_q <= 1'b0;
      end
      if (accept) begin
        out_valid_q <= 1'b1;
        out_data_q  <= xor_data;
        out_keep_q  <= bus.in_keep;
        out_last_q  <= bus.in_last;
        pld_valid_q <= 1'b1;
        pld_data_q  <= pld_next;
        pld_keep_q  <= bus.in_keep;
        cnt_q       <= cnt_q + CNT_W'(popcount16(bus.in_keep));
        if (keep_err) err_q <= 1'b1;
      end else begin
        if (bus.out_ready) out_valid_q <= 1'b0;
        if (bus.pld_ready) pld_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_keep  = out_keep_q;
  assign bus.out_last  = out_last_q;
  assign bus.pld_valid = pld_valid_q;
  assign bus.pld_data  = pld_data_q;
  assign bus.pld_keep  = pld_keep_q;

  assign ks_req       = (state == REQ);
  assign busy         = (state != IDLE);
  assign done         = (state == DRAIN) & !out_valid_q & !pld_valid_q;
  assign err          = err_q;
  assign pld_byte_cnt = cnt_q;

endmodule

// File: doc/chacha20_ks_xor_stage.md
Name: chacha20_ks_xor_stage

Overview:
Payload datapath stage directly downstream of chacha20_poly1305_core's keystream port and upstream of its Poly1305 payload port. It requests 512-bit keystream blocks, slices each into four 128-bit lanes and XORs them with the incoming payload stream to produce ciphertext (encrypt) or plaintext (decrypt). It forwards the ciphertext to the core's pld_* interface for authentication and counts payload bytes for the length block.

Parameters:
DATA_W, 128, payload beat width in bits.
KS_W, 512, keystream block width in bits.
LANES, 4, lanes per keystream block (KS_W/DATA_W).
CNT_W, 64, payload byte-counter width.

Ports:
clk  in  1  clock; single clock domain.
rst_n  in  1  reset, asynchronous assert, active-low.
start  in  1  one-cycle pulse; begins a message; accepted only in IDLE.
dir_enc  in  1  1 = encrypt, 0 = decrypt; sampled on accepted start.
ks_req  out  1  one-cycle keystream request to the core.
ks_valid  in  1  keystream block valid.
ks_data  in  KS_W  keystream block; lane i = ks_data[128*i +: 128].
in_valid  in  1  input beat valid.
in_data  in  DATA_W  input beat; byte j = in_data[8*j +: 8].
in_keep  in  DATA_W/8  byte enables; must be a prefix mask (bit 0 upward).
in_last  in  1  final beat of the message.
in_ready  out  1  input beat accepted when in_valid & in_ready.
out_valid  out  1  result beat valid.
out_data  out  DATA_W  XOR result; bytes with keep=0 forced to 0.
out_keep  out  DATA_W/8  copy of in_keep.
out_last  out  1  copy of in_last.
out_ready  in  1  downstream ready.
pld_valid  out  1  to core pld_valid.
pld_data  out  DATA_W  ciphertext: out_data when encrypting, masked in_data when decrypting.
pld_keep  out  DATA_W/8  copy of in_keep.
pld_ready  in  1  from core pld_ready.
pld_byte_cnt  out  CNT_W  payload bytes accepted in the current message.
busy  out  1  high in any state other than IDLE.
done  out  1  one-cycle pulse when the message has fully drained.
err  out  1  sticky keep-protocol error; cleared by start.

Behaviour:
- Reset values: ks_req, in_ready, out_valid, pld_valid, busy, done, err = 0. All data and keep outputs = 0. pld_byte_cnt = 0. State = IDLE, lane = 0.
- States: IDLE -> REQ -> WAIT_KS -> STREAM -> (REQ | DRAIN) -> IDLE.
- IDLE: on start, latch dir_enc, clear pld_byte_cnt and err, go to REQ.
- REQ: ks_req = 1 for exactly one cycle, then go to WAIT_KS.
- WAIT_KS: on ks_valid, load the 512-bit buffer, set lane = 0, go to STREAM. ks_valid is ignored in every other state.
- STREAM: in_ready = (!out_valid | out_ready) & (!pld_valid | pld_ready).
- On an accepted beat:
  - out_data = in_data ^ buf lane[lane], with unkept bytes zeroed.
  - out and pld registers load in the next cycle.
  - pld_byte_cnt += popcount(in_keep), wrapping modulo 2^CNT_W.
  - lane increments.
- Next state after an accepted beat:
  - in_last: go to DRAIN.
  - Otherwise, if lane was 3: go to REQ. No prefetch.
  - Otherwise: stay in STREAM.
- A partial last beat still consumes a whole lane; leftover keystream is discarded.
- Latency: start in cycle 0 -> ks_req in cycle 1. ks_valid in cycle t -> in_ready may rise in cycle t+1. Beat accepted in cycle t -> out_valid/pld_valid in cycle t+1.
- out and pld registers handshake independently. Each holds its value until its own ready is seen. No combinational path from out_ready or pld_ready to the data outputs.
- DRAIN: when both out_valid and pld_valid are 0, pulse done for one cycle and go to IDLE.
- Keep errors set err and the beat is still processed as given:
  - keep not a prefix mask;
  - keep != all-ones on a non-last beat;
  - keep == 0 on any beat.
- start outside IDLE is ignored.
- Asynchronous reset mid-message: immediately returns every register to its reset value; no done pulse.

Decomposition:
- Package chacha_pim_pkg holds:
  - DATA_W, KS_W, LANES;
  - the state enum {IDLE, REQ, WAIT_KS, STREAM, DRAIN};
  - a popcount16 function;
  - a prefix-mask check function.
- One sub-module: chacha_ks_lane_buf. It holds the 512-bit buffer and 2-bit lane pointer (load, advance) and outputs the current 128-bit lane and a last-lane flag.

Test Plan:
- ks_data = 0, encrypt, 4 full beats 128'h1111..4444 -> out_data equals input; exactly one ks_req; pld_byte_cnt = 64; done one cycle after the last out handshake.
- ks_data = all-ones, 5 full beats -> out_data = ~in_data; a second ks_req is issued after beat 4; beat 5 uses lane 0 of the new block; pld_byte_cnt = 80.
- Last beat keep = 16'h00FF, data 128'hFF..FF, ks = 0 -> out_keep = 00FF; out_data[127:64] = 0; count increases by 8; err = 0.
- Decrypt with out_ready held low for 10 cycles while pld_ready = 1 -> in_ready = 0 after the first beat; pld_data equals masked in_data; no beat lost or duplicated.
- Non-last beat keep = 16'h0FFF, then keep = 16'h00F0 -> err set and held until the next start; data still XORed.
- rst_n dropped while in STREAM after 2 beats -> all outputs 0 immediately; after release, a new start issues ks_req and lane restarts at 0.
